// File: rtl/mandel_pkg.sv
// Shared types and constants for the Mandelbrot colour pipeline.
package mandel_pkg;

    localparam int RBG_SIZE     = 24;
    localparam int NUM_ENGINES  = 11;
    localparam int IMAGE_WIDTH  = 640;
    localparam int IMAGE_HEIGHT = 480;
    localparam int LANE_W       = $clog2(NUM_ENGINES + 1);

    typedef logic [RBG_SIZE-1:0] rgb_t;
    typedef logic [LANE_W-1:0]   lane_cnt_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } ser_state_t;

    localparam lane_cnt_t MAX_LANES = lane_cnt_t'(NUM_ENGINES);

    // A batch is only drainable if it names between 1 and NUM_ENGINES lanes.
    function automatic logic lane_count_legal(input lane_cnt_t count);
        return (count != '0) && (count <= MAX_LANES);
    endfunction

endpackage

// File: rtl/mandel_pixel_serializer_if.sv
// Batch-in / pixel-out handshake bundle for the pixel serializer.
interface mandel_pixel_serializer_if;
    import mandel_pkg::*;

    logic      in_valid;
    logic      in_ready;
    rgb_t      in_rgb [NUM_ENGINES];
    lane_cnt_t in_count;
    logic      out_valid;
    logic      out_ready;
    rgb_t      out_data;
    logic      out_sof;
    logic      out_eol;

    // Producer of batches and consumer of pixels.
    modport master (
        output in_valid, in_rgb, in_count, out_ready,
        input  in_ready, out_valid, out_data, out_sof, out_eol
    );

    // The serializer itself.
    modport slave (
        input  in_valid, in_rgb, in_count, out_ready,
        output in_ready, out_valid, out_data, out_sof, out_eol
    );

endinterface

// File: rtl/mandel_raster_counter.sv
// Raster position tracker: advances x/y once per accepted pixel and flags
// start-of-frame and end-of-line for the current position.
module mandel_raster_counter
    import mandel_pkg::*;
#(
    parameter int WIDTH  = IMAGE_WIDTH,
    parameter int HEIGHT = IMAGE_HEIGHT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      advance,
    output logic [$clog2(WIDTH)-1:0]  x,
    output logic [$clog2(HEIGHT)-1:0] y,
    output logic                      sof,
    output logic                      eol
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] LAST_X = XW'(WIDTH - 1);
    localparam logic [YW-1:0] LAST_Y = YW'(HEIGHT - 1);

    assign eol = (x == LAST_X);
    assign sof = (x == '0) && (y == '0);

    // Step along the line, wrapping to the next line and then the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (eol) begin
                x <= '0;
                y <= (y == LAST_Y) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mandel_pixel_serializer.sv
// Pixel serializer: takes one batch of per-engine colours and streams it out
// one pixel per cycle with sof/eol raster markers.
// Optional build macro SERIALIZER_TEST_PATTERN_EN adds a test_mode input
// that replaces pixel colour with {x[7:0], y[7:0], 8'h80}.
module mandel_pixel_serializer
    import mandel_pkg::*;
#(
    parameter int IMAGE_WIDTH  = mandel_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = mandel_pkg::IMAGE_HEIGHT
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef SERIALIZER_TEST_PATTERN_EN
    input  logic                        test_mode,
`endif
    mandel_pixel_serializer_if.slave    bus,
    output logic                        err
);

    localparam int XW = $clog2(IMAGE_WIDTH);
    localparam int YW = $clog2(IMAGE_HEIGHT);

    ser_state_t state_reg;
    lane_cnt_t  lane_reg;
    lane_cnt_t  count_reg;
    logic       run_reg;
    rgb_t       buffer_reg [NUM_ENGINES];

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof;
    logic          eol;

    logic in_ready;
    logic out_valid;
    logic in_xfer;
    logic out_xfer;
    logic last_lane;
    logic batch_done;
    logic count_ok;
    rgb_t pix;

    assign out_valid  = (state_reg == DRAIN);
    assign out_xfer   = out_valid && bus.out_ready;
    assign in_xfer    = bus.in_valid && in_ready;
    assign count_ok   = lane_count_legal(bus.in_count);
    assign last_lane  = (lane_reg == count_reg - 1'b1);
    // An eol landing mid-batch ends the batch early: the leftover lanes would
    // otherwise spill onto the next line.
    assign batch_done = out_xfer && (last_lane || eol);

    // Ready while empty, or on the final transfer of a batch so the next one
    // can load with no bubble. run_reg keeps ready low while in reset.
    always_comb begin
        in_ready = 1'b0;
        if (run_reg) begin
            if (state_reg == IDLE) begin
                in_ready = 1'b1;
            end else begin
                in_ready = bus.out_ready && (last_lane || eol);
            end
        end
    end

    // Control FSM: load a batch, step through lanes, flag protocol errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            lane_reg  <= '0;
            count_reg <= '0;
            run_reg   <= 1'b0;
            err       <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            if (in_xfer) begin
                count_reg <= bus.in_count;
                lane_reg  <= '0;
                state_reg <= count_ok ? DRAIN : IDLE;
            end else if (batch_done) begin
                lane_reg  <= '0;
                state_reg <= IDLE;
            end else if (out_xfer) begin
                lane_reg  <= lane_reg + 1'b1;
            end
            if ((in_xfer && !count_ok) || (out_xfer && eol && !last_lane)) begin
                err <= 1'b1;
            end
        end
    end

    // Batch storage; contents are only visible while draining, so no reset.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            for (int i = 0; i < NUM_ENGINES; i++) begin
                buffer_reg[i] <= bus.in_rgb[i];
            end
        end
    end

    mandel_raster_counter #(
        .WIDTH  (IMAGE_WIDTH),
        .HEIGHT (IMAGE_HEIGHT)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .advance (out_xfer),
        .x       (x),
        .y       (y),
        .sof     (sof),
        .eol     (eol)
    );

    // Pick the colour for the current lane, or the coordinate pattern.
    always_comb begin
        pix = buffer_reg[lane_reg];
`ifdef SERIALIZER_TEST_PATTERN_EN
        if (test_mode) begin
            pix = rgb_t'({8'(x), 8'(y), 8'h80});
        end
`endif
    end

`ifndef SERIALIZER_TEST_PATTERN_EN
    // Position is only consumed by the test pattern.
    logic unused_raster;
    assign unused_raster = ^{x, y};
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? pix : '0;
    assign bus.out_sof   = out_valid && sof;
    assign bus.out_eol   = out_valid && eol;

endmodule

// File: tb/tb_mandel_pixel_serializer.sv
// Directed bench for mandel_pixel_serializer (reduced frame height).
module tb_mandel_pixel_serializer;
    import mandel_pkg::*;

    localparam int W = 640;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;
`ifdef SERIALIZER_TEST_PATTERN_EN
    logic test_mode = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int mx = 0;
    int my = 0;

    mandel_pixel_serializer_if bus ();

    mandel_pixel_serializer #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SERIALIZER_TEST_PATTERN_EN
        .test_mode (test_mode),
`endif
        .bus       (bus),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rgb_t pat(input int tag, input int l);
        return {tag[7:0], 4'hC, l[3:0], 8'h5A};
    endfunction

    function automatic rgb_t exp_pix(input int tag, input int l);
`ifdef SERIALIZER_TEST_PATTERN_EN
        if (test_mode) return {mx[7:0], my[7:0], 8'h80};
`endif
        return pat(tag, l);
    endfunction

    // Load a batch from IDLE and drain it, stalling out_ready at stall_pct.
    task automatic run_batch(input int cnt, input int tag, input int stall_pct);
        int waits;
        int stalls;
        logic r;
        waits = 0;
        while (bus.in_ready !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check("accept_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_count = lane_cnt_t'(cnt);
        for (int l = 0; l < NUM_ENGINES; l++) bus.in_rgb[l] = pat(tag, l);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int l = 0; l < cnt; l++) begin
            stalls = 0;
            forever begin
                check($sformatf("px_valid x=%0d y=%0d", mx, my), bus.out_valid, 1);
                check($sformatf("px_data x=%0d y=%0d", mx, my), bus.out_data, exp_pix(tag, l));
                check($sformatf("px_sof x=%0d y=%0d", mx, my), bus.out_sof, (mx == 0 && my == 0));
                check($sformatf("px_eol x=%0d y=%0d", mx, my), bus.out_eol, (mx == W - 1));
                r = (stalls < 20 && $urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
                bus.out_ready = r;
                #1;
                if (!(mx == W - 1 && l < cnt - 1))
                    check($sformatf("drain_ready lane=%0d", l), bus.in_ready, r && (l == cnt - 1));
                @(negedge clk);
                if (r) break;
                stalls++;
            end
            if (mx == W - 1) begin
                mx = 0;
                my = (my == H - 1) ? 0 : my + 1;
                if (l < cnt - 1) break;
            end else begin
                mx++;
            end
        end
        bus.out_ready = 1'b1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_count  = '0;
        bus.out_ready = 1'b1;
        for (int l = 0; l < NUM_ENGINES; l++) bus.in_rgb[l] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_sof", bus.out_sof, 0);
        check("rst_eol", bus.out_eol, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", bus.in_ready, 1);

        // Single full batch, no stalls
        run_batch(11, 1, 0);
        check("single_idle", bus.out_valid, 0);

        // Back-to-back batches with in_valid held high
        bus.in_valid = 1'b1;
        bus.in_count = lane_cnt_t'(11);
        for (int l = 0; l < NUM_ENGINES; l++) bus.in_rgb[l] = pat(2, l);
        @(negedge clk);
        for (int l = 0; l < NUM_ENGINES; l++) bus.in_rgb[l] = pat(3, l);
        for (int p = 0; p < 22; p++) begin
            check($sformatf("b2b_valid p=%0d", p), bus.out_valid, 1);
            check($sformatf("b2b_data p=%0d", p), bus.out_data, pat(p < 11 ? 2 : 3, p % 11));
            check($sformatf("b2b_sof p=%0d", p), bus.out_sof, 0);
            if (p == 10) check("b2b_ready_last", bus.in_ready, 1);
            if (p == 11) bus.in_valid = 1'b0;
            mx++;
            @(negedge clk);
        end
        check("b2b_idle", bus.out_valid, 0);

        // Reset while lane 5 of a batch is showing
        bus.in_valid = 1'b1;
        bus.in_count = lane_cnt_t'(11);
        for (int l = 0; l < NUM_ENGINES; l++) bus.in_rgb[l] = pat(4, l);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int l = 0; l < 5; l++) begin
            check($sformatf("mid_data lane=%0d", l), bus.out_data, pat(4, l));
            @(negedge clk);
        end
        check("mid_lane5", bus.out_data, pat(4, 5));
        rst = 1'b1;
        #1;
        check("midrst_valid", bus.out_valid, 0);
        check("midrst_data", bus.out_data, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        check("midrst_eol", bus.out_eol, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mx = 0;
        my = 0;
        @(negedge clk);
        check("midrst_ready_after", bus.in_ready, 1);

        // One full line with random stalls
        for (int b = 0; b < 58; b++) run_batch(11, 10 + b, 30);
        run_batch(2, 70, 30);

        // Line straddle: reach x=635 on line 1, then an 11-lane batch
        for (int b = 0; b < 57; b++) run_batch(11, 100 + b, 0);
        run_batch(8, 80, 0);
        check("pre_straddle_err", err, 0);
        run_batch(11, 81, 20);
        check("straddle_err", err, 1);
        check("straddle_idle", bus.out_valid, 0);
`ifdef SERIALIZER_TEST_PATTERN_EN
        test_mode = 1'b1;
`endif
        run_batch(11, 82, 0);
`ifdef SERIALIZER_TEST_PATTERN_EN
        test_mode = 1'b0;
`endif

        // Plain reset to clear err and position
        rst = 1'b1;
        @(negedge clk);
        check("rst2_err", err, 0);
        rst = 1'b0;
        mx = 0;
        my = 0;
        @(negedge clk);

        // Illegal lane counts
        bus.in_valid = 1'b1;
        bus.in_count = lane_cnt_t'(0);
        check("cnt0_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("cnt0_no_valid", bus.out_valid, 0);
        check("cnt0_err", err, 1);
        check("cnt0_ready_after", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_count = lane_cnt_t'(12);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("cnt12_no_valid", bus.out_valid, 0);
        @(negedge clk);
        check("cnt12_still_idle", bus.out_valid, 0);

        // Full reduced frame, then the next pixel must carry sof
        for (int b = 0; b < 232; b++) run_batch(11, b & 255, 0);
        run_batch(8, 90, 0);
        run_batch(1, 91, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mandel_pixel_serializer.md
Name: mandel_pixel_serializer

Overview:
- Consumer side of the iteration-to-colour lookup stage.
- Accepts one batch of NUM_ENGINES parallel 24-bit RGB values (one per Mandelbrot engine) on a valid/ready handshake.
- Emits the batch as a one-pixel-per-cycle video stream with start-of-frame and end-of-line markers, tracking x/y raster position for the downstream packer.

Parameters:
- RBG_SIZE, 24, pixel width in bits.
- NUM_ENGINES, 11, lanes per input batch.
- IMAGE_WIDTH, 640, pixels per line.
- IMAGE_HEIGHT, 480, lines per frame.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  batch present.
- in_ready  out  1  block can accept a batch this cycle.
- in_rgb  in  RBG_SIZE x NUM_ENGINES (unpacked)  lane colours; lane 0 is leftmost pixel.
- in_count  in  $clog2(NUM_ENGINES+1)  number of valid lanes, starting at lane 0.
- out_valid  out  1  pixel present.
- out_ready  in  1  sink accepts pixel.
- out_data  out  RBG_SIZE  pixel colour.
- out_sof  out  1  first pixel of frame (x=0, y=0).
- out_eol  out  1  last pixel of line (x=IMAGE_WIDTH-1).
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset values: in_ready=0 during reset, 1 from the first cycle after release. out_valid=0, out_data=0, out_sof=0, out_eol=0, err=0. Internal x=0, y=0, lane=0, state=IDLE.
- Input transfer occurs on the rising clk edge when in_valid && in_ready. Output transfer occurs on the rising clk edge when out_valid && out_ready.
- States:
  - IDLE: buffer empty; in_ready=1; out_valid=0. A valid transfer latches in_rgb and in_count, sets lane=0, and moves to DRAIN.
  - DRAIN: out_valid=1; out_data=buffer[lane]. Each output transfer increments lane and advances x/y.
  - When the transfer is on lane in_count-1, the batch is done. If in_valid is high in that same cycle, the new batch loads and the block stays in DRAIN with no bubble. Otherwise it returns to IDLE.
  - in_ready in DRAIN is 1 only when (lane==count-1 && out_ready).
- Latency: first pixel of a batch is visible 1 cycle after the input transfer. Sustained throughput is 1 pixel/cycle with back-to-back batches.
- While out_valid=1, out_data, out_sof and out_eol are held stable until the transfer occurs.
- Raster counters:
  - x increments per output transfer.
  - At x==IMAGE_WIDTH-1: out_eol=1, then x wraps to 0 and y increments.
  - At y==IMAGE_HEIGHT-1 with eol: y wraps to 0.
  - out_sof = (x==0 && y==0).
- Line straddle: when eol is emitted on a lane below count-1, the remaining lanes of that batch are discarded and err is set. The block then takes the batch-done path that same cycle.
- Illegal in_count:
  - Values 0 or >NUM_ENGINES: the batch is accepted, no pixels are emitted, err is set, state stays IDLE.
  - in_count is registered only at the input transfer; changes at any other time are ignored.
- out_ready low for any duration: no state changes, buffer and counters hold.
- Reset mid-batch: the buffer is discarded and counters return to 0. The next accepted pixel carries sof.
- err clears only on rst.

Optional Feature:
- Macro: SERIALIZER_TEST_PATTERN_EN.
- With the macro defined:
  - Extra input port test_mode (1 bit).
  - When test_mode=1 at the output transfer, out_data = {x[7:0], y[7:0], 8'h80} instead of buffer[lane].
  - Handshake, counters, sof/eol and err behave identically.
- Without the macro: the port does not exist and out_data is always buffer[lane].

Decomposition:
- Shared package mandel_pkg holds:
  - rgb_t (logic [RBG_SIZE-1:0]).
  - Constants IMAGE_WIDTH, IMAGE_HEIGHT, NUM_ENGINES.
  - Typedef lane_cnt_t for in_count.
  - State enum ser_state_t {IDLE, DRAIN}.
- One natural sub-module: mandel_raster_counter. It takes clk, rst and an advance input, and outputs x, y, sof and eol. It is reusable by the engine-dispatch side.

Test Plan:
- Single batch, in_count=11, out_ready=1 after reset: 11 pixels on consecutive cycles, first 1 cycle after accept; pixel 0 has sof=1; in_ready returns 1 on the 11th transfer cycle.
- Back-to-back batches, in_valid held high, out_ready=1: 22 pixels, no bubble between lane 10 and the next lane 0, and no gap in out_valid.
- Random out_ready with a 30% stall rate over one full line (58 batches of 11 plus 1 batch of 2): every pixel is held stable while stalled; eol appears only on pixel 639; the next pixel has x=0, y=1.
- Line straddle: x=635 with in_count=11: eol on lane 4, lanes 5-10 dropped, err=1, next batch starts at x=0.
- in_count=0: accepted with in_ready=1, no out_valid, err=1. Then a full frame of 640x480 ends with eol at y=479, and the next pixel has sof=1.
- Reset asserted mid-batch at lane 5: the outputs go to their reset values straight away with no clock edge needed. After release, the next batch's first pixel has sof=1. With SERIALIZER_TEST_PATTERN_EN and test_mode=1, pixel (x=3, y=2) = 24'h030280.
